// File: rtl/ring_seq_pkg.sv
// Shared types, constants and successor rule for the ring/Johnson sequence monitor.
package ring_seq_pkg;

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } seq_state_e;

    localparam int RING_LEN = 8;
    localparam int JOHN_LEN = 16;

    // Ring right shift walks the one-hot bit downward, left shift upward.
    function automatic logic [3:0] seq_succ(input logic [3:0] idx, input logic ring,
                                            input logic mode);
        logic [3:0] nxt;
        if (ring) begin
            nxt = mode ? ((idx - 4'd1) & 4'(RING_LEN - 1)) : ((idx + 4'd1) & 4'(RING_LEN - 1));
        end else begin
            nxt = (idx + 4'd1) & 4'(JOHN_LEN - 1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ring_seq_decode.sv
// Combinational decode of an 8-bit ring or Johnson counter word to a phase index.
module ring_seq_decode
    import ring_seq_pkg::*;
(
    input  logic [7:0] count_in,
    input  logic       ring,
    output logic [3:0] idx,
    output logic       legal
);

    always_comb begin
        idx   = 4'd0;
        legal = 1'b0;
        if (ring) begin
            for (int i = 0; i < RING_LEN; i++) begin
                if (count_in == (8'd1 << i)) begin
                    idx   = 4'(i);
                    legal = 1'b1;
                end
            end
        end else begin
            if (count_in == 8'h00) begin
                legal = 1'b1;
            end
            // Filling phase: ones enter from the MSB.
            for (int k = 1; k <= 8; k++) begin
                if (count_in == ~(8'hFF >> k)) begin
                    idx   = 4'(k);
                    legal = 1'b1;
                end
            end
            // Draining phase: ones remain only toward the LSB.
            for (int j = 1; j < 8; j++) begin
                if (count_in == (8'hFF >> j)) begin
                    idx   = 4'(8 + j);
                    legal = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ring_seq_monitor.sv
// Sequence monitor for ring/Johnson counter output: decode, successor check, lock FSM.
// Optional wrap pulse enabled by defining RING_SEQ_MON_WRAP_EN.
module ring_seq_monitor
    import ring_seq_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       count_in,
    input  logic             ring,
    input  logic             mode,
    output logic [3:0]       phase,
    output logic             phase_vld,
    output logic             lock,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             reinit_req,
    output logic             wrap
);

    localparam logic [3:0] LOCK_STEPS = 4'(LOCK_CNT);

    logic [3:0]       dec_idx;
    logic             dec_legal;
    seq_state_e       state_q, state_d;
    logic [3:0]       step_q, step_d;
    logic [3:0]       phase_q, phase_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;
    logic             reinit_q, reinit_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic             snap_vld_q, snap_vld_d;
    logic             snap_ring_q, snap_ring_d;
    logic             snap_mode_q, snap_mode_d;
    logic             cfg_chg;
    logic             step_ok;

    ring_seq_decode u_decode (
        .count_in (count_in),
        .ring     (ring),
        .idx      (dec_idx),
        .legal    (dec_legal)
    );

    // Snapshot is captured on the first clock after reset, so no change is seen then.
    assign cfg_chg = snap_vld_q && ((ring != snap_ring_q) || (mode != snap_mode_q));
    assign step_ok = dec_legal && vld_q && (dec_idx == seq_succ(phase_q, ring, mode));

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        phase_d     = phase_q;
        vld_d       = vld_q;
        err_d       = 1'b0;
        reinit_d    = 1'b0;
        cnt_d       = cnt_q;
        snap_vld_d  = 1'b1;
        snap_ring_d = ring;
        snap_mode_d = mode;

        if (en) begin
            phase_d = dec_idx;
            vld_d   = dec_legal;
        end

        if (cfg_chg) begin
            state_d = UNLOCK;
            step_d  = 4'd0;
        end else if (state_q == FAULT) begin
            state_d = UNLOCK;
        end else if (en) begin
            unique case (state_q)
                UNLOCK: begin
                    if (dec_legal) begin
                        state_d = TRACK;
                        step_d  = 4'd0;
                    end
                end
                TRACK: begin
                    if (!dec_legal) begin
                        state_d = UNLOCK;
                    end else if (step_ok) begin
                        step_d = step_q + 4'd1;
                        if (step_q + 4'd1 == LOCK_STEPS) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        step_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (!step_ok) begin
                        state_d  = FAULT;
                        err_d    = 1'b1;
                        reinit_d = 1'b1;
                        cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    end
                end
                default: state_d = UNLOCK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= UNLOCK;
            step_q      <= 4'd0;
            phase_q     <= 4'd0;
            vld_q       <= 1'b0;
            err_q       <= 1'b0;
            reinit_q    <= 1'b0;
            cnt_q       <= '0;
            snap_vld_q  <= 1'b0;
            snap_ring_q <= 1'b0;
            snap_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            phase_q     <= phase_d;
            vld_q       <= vld_d;
            err_q       <= err_d;
            reinit_q    <= reinit_d;
            cnt_q       <= cnt_d;
            snap_vld_q  <= snap_vld_d;
            snap_ring_q <= snap_ring_d;
            snap_mode_q <= snap_mode_d;
        end
    end

`ifdef RING_SEQ_MON_WRAP_EN
    logic wrap_q, wrap_d;

    // A correct step that stays in LOCKED and lands on idx 0 closes one revolution.
    assign wrap_d = en && !cfg_chg && (state_q == LOCKED) && step_ok && (dec_idx == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;
`else
    assign wrap = 1'b0;
`endif

    assign phase      = phase_q;
    assign phase_vld  = vld_q;
    assign lock       = (state_q == LOCKED);
    assign err        = err_q;
    assign err_cnt    = cnt_q;
    assign reinit_req = reinit_q;

endmodule
